// File: rtl/up_param_pkg.sv
// Shared definitions for the up_param multicycle core: opcode/funct constants,
// FSM state encoding, ALU operations and instruction classes.
package up_param_pkg;

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcLui    = 7'b0110111;

  localparam logic [31:0] InstrEcall = 32'h0000_0073;

  localparam logic [2:0] F3AddSub = 3'b000;
  localparam logic [2:0] F3Slt    = 3'b010;
  localparam logic [2:0] F3Or     = 3'b110;
  localparam logic [2:0] F3And    = 3'b111;
  localparam logic [2:0] F3Beq    = 3'b000;
  localparam logic [2:0] F3Bne    = 3'b001;
  localparam logic [2:0] F3Word   = 3'b010;
  localparam logic [2:0] F3Dword  = 3'b011;

  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Sub  = 7'b0100000;

  // Encoding is visible on state_out, so values are pinned.
  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    AluAdd,
    AluSub,
    AluAnd,
    AluOr,
    AluSlt,
    AluPassB
  } alu_op_e;

  typedef enum logic [2:0] {
    ClsNone,
    ClsAlu,
    ClsLoad,
    ClsStore,
    ClsBranch,
    ClsJal,
    ClsEcall
  } instr_cls_e;

  // Loads/stores are always register-sized: ld/sd on RV64, lw/sw on RV32.
  function automatic logic [2:0] mem_funct3(int unsigned xlen);
    return (xlen == 64) ? F3Dword : F3Word;
  endfunction

endpackage

// File: rtl/up_param_regfile.sv
// 32-entry register file: two asynchronous read ports, one synchronous write
// port, x0 hard-wired to zero.
module regfile_param
  import up_param_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      raddr_a,
  output logic [XLEN-1:0] rdata_a,
  input  logic [4:0]      raddr_b,
  output logic [XLEN-1:0] rdata_b,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] regs [32];

  // Synchronous clear and write; writes to x0 are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  // Asynchronous reads with x0 forced to zero.
  always_comb begin
    rdata_a = (raddr_a == 5'd0) ? '0 : regs[raddr_a];
    rdata_b = (raddr_b == 5'd0) ? '0 : regs[raddr_b];
  end

endmodule

// File: rtl/up_param.sv
// up_param: multicycle RV subset core (add/sub/and/or/slt, addi, ld/sd or lw/sw,
// beq/bne, jal, lui, ecall). FSM FETCH -> DECODE -> EXEC -> [MEM] -> [WB].
// Optional macro UP_PARAM_TRAP_EN: unsupported opcodes halt the core with
// pc_out pointing at the offending instruction; otherwise they act as a NOP.
module up_param
  import up_param_pkg::*;
#(
  parameter int unsigned XLEN     = 64,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [31:0]     imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_ready,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_ready,
  output logic [XLEN-1:0] pc_out,
  output logic [2:0]      state_out,
  output logic            halted
);

  state_e          state, state_next;
  logic [XLEN-1:0] pc, a, b, aluout, mdr;
  logic [31:0]     ir;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rs1, rs2, rd;

  instr_cls_e      cls;
  alu_op_e         alu_op;
  logic            use_imm;
  logic signed [31:0] imm32;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] alu_b, alu_res;
  logic            br_taken;

  logic [XLEN-1:0] rf_rdata_a, rf_rdata_b, rf_wdata;
  logic            rf_we;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign funct7 = ir[31:25];

  // Classify the held instruction and pick its ALU operation.
  always_comb begin
    cls     = ClsNone;
    alu_op  = AluAdd;
    use_imm = 1'b0;
    if (ir == InstrEcall) begin
      cls = ClsEcall;
    end else begin
      case (opcode)
        OpcOp: begin
          if (funct7 == F7Sub && funct3 == F3AddSub) begin
            cls    = ClsAlu;
            alu_op = AluSub;
          end else if (funct7 == F7Base) begin
            case (funct3)
              F3AddSub: begin cls = ClsAlu; alu_op = AluAdd; end
              F3Slt:    begin cls = ClsAlu; alu_op = AluSlt; end
              F3Or:     begin cls = ClsAlu; alu_op = AluOr;  end
              F3And:    begin cls = ClsAlu; alu_op = AluAnd; end
              default:  cls = ClsNone;
            endcase
          end
        end
        OpcOpImm: begin
          if (funct3 == F3AddSub) begin
            cls     = ClsAlu;
            use_imm = 1'b1;
          end
        end
        OpcLoad: begin
          if (funct3 == mem_funct3(XLEN)) begin
            cls     = ClsLoad;
            use_imm = 1'b1;
          end
        end
        OpcStore: begin
          if (funct3 == mem_funct3(XLEN)) begin
            cls     = ClsStore;
            use_imm = 1'b1;
          end
        end
        OpcBranch: begin
          if (funct3 == F3Beq || funct3 == F3Bne) cls = ClsBranch;
        end
        OpcJal: cls = ClsJal;
        OpcLui: begin
          cls     = ClsAlu;
          alu_op  = AluPassB;
          use_imm = 1'b1;
        end
        default: cls = ClsNone;
      endcase
    end
  end

  // Immediate extraction by format, kept 32-bit then sign-extended to XLEN.
  always_comb begin
    case (opcode)
      OpcStore:  imm32 = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      OpcBranch: imm32 = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      OpcJal:    imm32 = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      OpcLui:    imm32 = {ir[31:12], 12'b0};
      default:   imm32 = {{20{ir[31]}}, ir[31:20]};
    endcase
  end

  assign imm = XLEN'(imm32);

  // ALU: operand A is always the latched rs1 value.
  always_comb begin
    alu_b   = use_imm ? imm : b;
    alu_res = '0;
    case (alu_op)
      AluAdd:   alu_res = a + alu_b;
      AluSub:   alu_res = a - alu_b;
      AluAnd:   alu_res = a & alu_b;
      AluOr:    alu_res = a | alu_b;
      AluSlt:   alu_res[0] = ($signed(a) < $signed(alu_b));
      AluPassB: alu_res = alu_b;
      default:  alu_res = '0;
    endcase
    br_taken = (funct3 == F3Bne) ? (a != b) : (a == b);
  end

  // Register writes: WB stage, or the link write of jal in EXEC. Reset masks
  // the write so an aborted instruction leaves no trace.
  always_comb begin
    rf_we    = !rst && ((state == StWb) || (state == StExec && cls == ClsJal));
    rf_wdata = pc;
    if (state == StWb) rf_wdata = (cls == ClsLoad) ? mdr : aluout;
  end

  regfile_param #(
    .XLEN(XLEN)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .raddr_a(rs1),
    .rdata_a(rf_rdata_a),
    .raddr_b(rs2),
    .rdata_b(rf_rdata_b),
    .we     (rf_we),
    .waddr  (rd),
    .wdata  (rf_wdata)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= StFetch;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      StFetch: if (imem_ready) state_next = StDecode;
      StDecode: begin
        case (cls)
          ClsEcall: state_next = StHalt;
`ifdef UP_PARAM_TRAP_EN
          ClsNone:  state_next = StHalt;
`else
          ClsNone:  state_next = StFetch;
`endif
          default:  state_next = StExec;
        endcase
      end
      StExec: begin
        case (cls)
          ClsAlu:             state_next = StWb;
          ClsLoad, ClsStore:  state_next = StMem;
          default:            state_next = StFetch;
        endcase
      end
      StMem: if (dmem_ready) state_next = (cls == ClsStore) ? StFetch : StWb;
      StWb:    state_next = StFetch;
      StHalt:  state_next = StHalt;
      default: state_next = StFetch;
    endcase
  end

  // Outputs; requests are masked during reset so an aborted handshake drops at once.
  always_comb begin
    imem_req   = !rst && (state == StFetch);
    dmem_req   = !rst && (state == StMem);
    dmem_we    = dmem_req && (cls == ClsStore);
    halted     = (state == StHalt);
    imem_addr  = pc[31:0];
    dmem_addr  = aluout;
    dmem_wdata = b;
    pc_out     = pc;
    state_out  = state;
  end

  // Datapath registers; pc already points past the instruction after FETCH.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RESET_PC[XLEN-1:0];
      ir     <= '0;
      a      <= '0;
      b      <= '0;
      aluout <= '0;
      mdr    <= '0;
    end else begin
      case (state)
        StFetch: begin
          if (imem_ready) begin
            ir <= imem_rdata;
            pc <= pc + XLEN'(4);
          end
        end
        StDecode: begin
          a      <= rf_rdata_a;
          b      <= rf_rdata_b;
          aluout <= pc - XLEN'(4) + imm;
`ifdef UP_PARAM_TRAP_EN
          if (cls == ClsNone) pc <= pc - XLEN'(4);
`endif
        end
        StExec: begin
          case (cls)
            ClsAlu, ClsLoad, ClsStore: aluout <= alu_res;
            ClsBranch:                 if (br_taken) pc <= aluout;
            ClsJal:                    pc <= aluout;
            default:                   ;
          endcase
        end
        StMem: if (dmem_ready && cls == ClsLoad) mdr <= dmem_rdata;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/up_param.md
UP_PARAM -- requirements
Module: up_param

Interface
REQ-001 The module SHALL have parameter XLEN, default 64, meaning datapath/register width (32 or 64 legal).
REQ-002 The module SHALL have parameter RESET_PC, default 0, meaning PC value after reset.
REQ-003 Port clk  in  1  the single clock; all state updates on rising edge.
REQ-004 Port rst  in  1  reset, synchronous and active-high.
REQ-005 Port imem_req  out  1, imem_addr  out  32, imem_rdata  in  32, imem_ready  in  1  instruction fetch handshake.
REQ-006 Port dmem_req  out  1, dmem_we  out  1, dmem_addr  out  XLEN, dmem_wdata  out  XLEN, dmem_rdata  in  XLEN, dmem_ready  in  1  data memory handshake.
REQ-007 Port pc_out  out  XLEN, state_out  out  3, halted  out  1  debug/status.

Function
REQ-008 The core SHALL be a multicycle RV subset: add, sub, and, or, slt (R); addi (I); ld/lw, sd/sw (XLEN-sized); beq, bne; jal; lui.
REQ-009 The FSM SHALL have states FETCH, DECODE, EXEC, MEM, WB, HALT, encoded on state_out as 0..5.
REQ-010 FETCH SHALL hold imem_req=1, imem_addr=PC[31:0] until imem_ready=1; on that edge IR<=imem_rdata, PC<=PC+4, next DECODE.
REQ-011 DECODE SHALL latch A<=x[rs1], B<=x[rs2], and compute branch/jal target = oldPC + sign-extended immediate into ALUOUT.
REQ-012 EXEC SHALL: R/I/lui -> result to ALUOUT, next WB; ld/sd -> address A+imm to ALUOUT, next MEM; beq/bne -> PC<=target if taken, next FETCH; jal -> x[rd]<=oldPC+4, PC<=target, next FETCH.
REQ-013 MEM SHALL hold dmem_req=1, dmem_addr=ALUOUT, dmem_we=1 for sd with dmem_wdata=B, until dmem_ready=1; sd then FETCH, ld latches MDR<=dmem_rdata then WB.
REQ-014 WB SHALL write ALUOUT (or MDR for ld) to x[rd], next FETCH.
REQ-015 Zero-wait latency SHALL be: branch 3, jal 3, sd 4, R/I/lui 4, ld 5 cycles; each wait-state cycle adds exactly one.
REQ-016 Register x0 SHALL read 0; writes to x0 SHALL be discarded.
REQ-017 slt SHALL be signed, producing 1 or 0 zero-extended to XLEN; all adds wrap modulo 2^XLEN.
REQ-018 Immediates SHALL be sign-extended to XLEN; lui result = imm[31:12]<<12 sign-extended.
REQ-019 imem_req and dmem_req SHALL never be asserted in the same cycle; request outputs SHALL stay stable while ready=0.
REQ-020 HALT SHALL be entered on ecall (0x00000073); halted=1, no requests, PC frozen until rst.

Reset
REQ-021 On rst=1: PC<=RESET_PC, state<=FETCH, IR/A/B/ALUOUT/MDR<=0, all registers<=0, halted=0, imem_req/dmem_req/dmem_we=0 in the following cycle.
REQ-022 rst asserted mid-handshake SHALL abort the transaction; any imem_ready/dmem_ready in that cycle SHALL be ignored and no register or memory write SHALL result.

Configuration
REQ-023 Macro UP_PARAM_TRAP_EN: defined -> unsupported opcode in DECODE enters HALT with halted=1 and pc_out = faulting instruction address; undefined -> unsupported opcode executes as NOP (FETCH next, 2 cycles).

Structure
REQ-024 Package up_param_pkg SHALL hold opcode/funct constants, the state enum, and ALU operation enum.
REQ-025 Register file SHALL be sub-module regfile_param (2 async read, 1 sync write, XLEN parameter, x0 forced 0).

Verification
REQ-026 addi x1,x0,5; addi x2,x0,-3; add x3,x1,x2 with zero wait -> x3=2 after 12 cycles, pc_out=RESET_PC+12.
REQ-027 slt x4,x2,x1 (x2=-3, x1=5) -> x4=1; sub x5,x0,x1 -> x5 = 2^XLEN-5.
REQ-028 sd x1,8(x0) then ld x6,8(x0), dmem_ready delayed 3 cycles each -> x6=5, sd 7 cycles, ld 8 cycles, requests stable while waiting.
REQ-029 beq x1,x1,+16 -> PC=branch addr+16 after 3 cycles; bne x1,x1,+16 -> PC=addr+4; jal x7,-8 -> x7=addr+4, PC=addr-8.
REQ-030 addi x0,x0,9 -> x0 reads 0; rst pulsed during FETCH wait -> IR unchanged, state=FETCH, PC=RESET_PC.
REQ-031 Opcode 0x7F: with UP_PARAM_TRAP_EN -> halted=1, state_out=5; without -> next instruction executes; ecall -> halted=1 in both builds.
